// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Shared types for the DDS sequencer: waveform codes and
//               the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

  // Waveform codes; these select one of the four waveform ROMs.
  typedef enum logic [1:0] {
    SIN = 2'b00,
    TIR = 2'b01,
    SAW = 2'b10,
    SQU = 2'b11
  } wav_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dds_phase_acc.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_acc
// Description : Phase accumulator with carry (wrap) detection and the
//               phase-offset add that forms the ROM address.
// Revision    : 1.0 - initial release
// Ports       : clk_i, rst_i  - clock, synchronous active-high reset
//               clr_i         - force accumulator to zero at next edge
//               adv_i         - add ftw_i this cycle
//               ftw_i, pow_i  - active tuning word / phase offset
//               addr_o        - top ADDR_BIT accumulator bits + pow_i
//               wrap_o        - carry out of this cycle's add
// ============================================================================
module dds_phase_acc #(
  parameter int ACC_BIT  = 32,
  parameter int ADDR_BIT = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                adv_i,
  input  logic [ACC_BIT-1:0]  ftw_i,
  input  logic [ADDR_BIT-1:0] pow_i,
  output logic [ADDR_BIT-1:0] addr_o,
  output logic                wrap_o
);

  logic [ACC_BIT-1:0] acc_q;
  logic [ACC_BIT:0]   sum;

  // One extra bit holds the carry; wrap only counts while advancing.
  assign sum    = {1'b0, acc_q} + {1'b0, ftw_i};
  assign wrap_o = adv_i & sum[ACC_BIT];
  assign addr_o = acc_q[ACC_BIT-1 -: ADDR_BIT] + pow_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_q <= '0;
    end else if (adv_i) begin
      acc_q <= sum[ACC_BIT-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dds_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_ctrl
// Description : DDS waveform sequencer. Owns the phase accumulator, applies
//               new configuration only at phase wraps, counts burst periods
//               and produces a data_valid strobe aligned to ROM output.
// Revision    : 1.0 - initial release
// Ports       : sclk, rst        - clock, synchronous active-high reset
//               start, stop      - run control
//               cfg_*            - valid/ready configuration port
//               wav_select, addr, en - ROM selector drive
//               data_valid       - ROM data valid this cycle
//               busy, wrap, done - status
// ============================================================================
module dds_ctrl
  import dds_pkg::*;
#(
  parameter int ACC_BIT  = 32,
  parameter int ADDR_BIT = 12,
  parameter int CNT_BIT  = 16,
  parameter int ROM_LAT  = 1
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ACC_BIT-1:0]  cfg_ftw,
  input  logic [ADDR_BIT-1:0] cfg_pow,
  input  logic [1:0]          cfg_wav,
  input  logic [CNT_BIT-1:0]  cfg_ncyc,
  output logic [1:0]          wav_select,
  output logic [ADDR_BIT-1:0] addr,
  output logic                en,
  output logic                data_valid,
  output logic                busy,
  output logic                wrap,
  output logic                done
);

  state_t              state_q, state_d;
  // shadow config
  logic [ACC_BIT-1:0]  ftw_q, ftw_d;
  logic [ADDR_BIT-1:0] pow_q, pow_d;
  wav_t                wav_q, wav_d;
  logic [CNT_BIT-1:0]  ncyc_q, ncyc_d;
  logic                pending_q, pending_d;
  // active config
  logic [ACC_BIT-1:0]  ftw_a_q, ftw_a_d;
  logic [ADDR_BIT-1:0] pow_a_q, pow_a_d;
  wav_t                wav_a_q, wav_a_d;
  logic [CNT_BIT-1:0]  ncyc_a_q, ncyc_a_d;

  logic [CNT_BIT-1:0]  pcnt_q, pcnt_d;
  logic                stop_req_q, stop_req_d;
  logic                done_q, done_d;
  logic [ROM_LAT-1:0]  en_dly_q;
  logic [ROM_LAT-1:0]  blank_q;

  logic                cfg_acc;
  logic [CNT_BIT-1:0]  pcnt_inc;
  logic                run;

  assign run      = (state_q == RUN);
  assign cfg_acc  = cfg_valid & ~pending_q;
  assign pcnt_inc = pcnt_q + CNT_BIT'(1);

  dds_phase_acc #(
    .ACC_BIT  (ACC_BIT),
    .ADDR_BIT (ADDR_BIT)
  ) u_acc (
    .clk_i  (sclk),
    .rst_i  (rst),
    .clr_i  (state_d == IDLE),
    .adv_i  (run),
    .ftw_i  (ftw_a_q),
    .pow_i  (pow_a_q),
    .addr_o (addr),
    .wrap_o (wrap)
  );

  always_comb begin
    state_d    = state_q;
    ftw_d      = ftw_q;
    pow_d      = pow_q;
    wav_d      = wav_q;
    ncyc_d     = ncyc_q;
    pending_d  = pending_q;
    ftw_a_d    = ftw_a_q;
    pow_a_d    = pow_a_q;
    wav_a_d    = wav_a_q;
    ncyc_a_d   = ncyc_a_q;
    pcnt_d     = pcnt_q;
    stop_req_d = stop_req_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        pcnt_d     = '0;
        stop_req_d = 1'b0;
        // A config still shadowed when a burst ended is promoted here so
        // the port never stays blocked while idle.
        if (pending_q) begin
          ftw_a_d   = ftw_q;
          pow_a_d   = pow_q;
          wav_a_d   = wav_q;
          ncyc_a_d  = ncyc_q;
          pending_d = 1'b0;
        end else if (cfg_acc) begin
          ftw_a_d  = cfg_ftw;
          pow_a_d  = cfg_pow;
          wav_a_d  = wav_t'(cfg_wav);
          ncyc_a_d = cfg_ncyc;
        end
        if (start && !stop) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (cfg_acc) begin
          ftw_d     = cfg_ftw;
          pow_d     = cfg_pow;
          wav_d     = wav_t'(cfg_wav);
          ncyc_d    = cfg_ncyc;
          pending_d = 1'b1;
        end
        if (stop) begin
          stop_req_d = 1'b1;
        end

        // A zero tuning word never wraps, so a stop completes immediately.
        if (ftw_a_q == '0 && (stop_req_q || stop)) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          stop_req_d = 1'b0;
          pcnt_d     = '0;
        end else if (wrap) begin
          if (stop_req_q || (ncyc_a_q != '0 && pcnt_inc == ncyc_a_q)) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            stop_req_d = 1'b0;
            pcnt_d     = '0;
          end else if (pending_q) begin
            // pending_q (not pending_d) is tested, so a config accepted in
            // this very cycle waits for the following wrap.
            ftw_a_d   = ftw_q;
            pow_a_d   = pow_q;
            wav_a_d   = wav_q;
            ncyc_a_d  = ncyc_q;
            pending_d = 1'b0;
            pcnt_d    = '0;
          end else begin
            pcnt_d = pcnt_inc;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= IDLE;
      ftw_q      <= '0;
      pow_q      <= '0;
      wav_q      <= SIN;
      ncyc_q     <= '0;
      pending_q  <= 1'b0;
      ftw_a_q    <= '0;
      pow_a_q    <= '0;
      wav_a_q    <= SIN;
      ncyc_a_q   <= '0;
      pcnt_q     <= '0;
      stop_req_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ftw_q      <= ftw_d;
      pow_q      <= pow_d;
      wav_q      <= wav_d;
      ncyc_q     <= ncyc_d;
      pending_q  <= pending_d;
      ftw_a_q    <= ftw_a_d;
      pow_a_q    <= pow_a_d;
      wav_a_q    <= wav_a_d;
      ncyc_a_q   <= ncyc_a_d;
      pcnt_q     <= pcnt_d;
      stop_req_q <= stop_req_d;
      done_q     <= done_d;
    end
  end

  // en delayed by the ROM latency; blank_q marks the ROM_LAT cycles after a
  // waveform switch, when the newly selected ROM still shows stale data.
  always_ff @(posedge sclk) begin
    if (rst) begin
      en_dly_q <= '0;
      blank_q  <= '0;
    end else begin
      en_dly_q[0] <= run;
      blank_q[0]  <= (wav_a_d != wav_a_q);
      for (int i = 1; i < ROM_LAT; i++) begin
        en_dly_q[i] <= en_dly_q[i-1];
        blank_q[i]  <= blank_q[i-1];
      end
    end
  end

  assign cfg_ready  = ~pending_q;
  assign wav_select = wav_a_q;
  assign en         = run;
  assign busy       = run;
  assign done       = done_q;
  assign data_valid = en_dly_q[ROM_LAT-1] & ~(|blank_q);

endmodule
`default_nettype wire

// File: tb/tb_dds_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_ctrl
// Description : Self-checking bench for dds_ctrl: a table of vectors, hand
//               sequences for the multi-cycle corner cases, and random
//               stimulus, all tracked by a period-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_ctrl;

  localparam int ACC = 16;
  localparam int AD  = 12;
  localparam int CNT = 16;
  localparam int LAT = 1;
  localparam int MOD = 1 << ACC;

  typedef struct {
    logic            rst, start, stop, cv;
    logic [ACC-1:0]  ftw;
    logic [AD-1:0]   pow;
    logic [1:0]      wav;
    logic [CNT-1:0]  ncyc;
  } stim_t;

  typedef struct {
    stim_t           s;
    logic [AD-1:0]   addr;
    logic            en, wrap, done, dv, rdy;
  } vec_t;

  logic           sclk, rst, start, stop, cfg_valid, cfg_ready;
  logic [ACC-1:0] cfg_ftw;
  logic [AD-1:0]  cfg_pow, addr;
  logic [1:0]     cfg_wav, wav_select;
  logic [CNT-1:0] cfg_ncyc;
  logic           en, data_valid, busy, wrap, done;

  int errs   = 0;
  int checks = 0;

  dds_ctrl #(
    .ACC_BIT (ACC), .ADDR_BIT (AD), .CNT_BIT (CNT), .ROM_LAT (LAT)
  ) dut (
    .sclk (sclk), .rst (rst), .start (start), .stop (stop),
    .cfg_valid (cfg_valid), .cfg_ready (cfg_ready), .cfg_ftw (cfg_ftw),
    .cfg_pow (cfg_pow), .cfg_wav (cfg_wav), .cfg_ncyc (cfg_ncyc),
    .wav_select (wav_select), .addr (addr), .en (en),
    .data_valid (data_valid), .busy (busy), .wrap (wrap), .done (done)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // ---------------- reference model (period-level view) ----------------
  int m_busy, m_phase, m_per, m_sreq, m_pend, m_done;
  int m_ftw, m_pow, m_wav, m_ncyc;        // active
  int s_ftw, s_pow, s_wav, s_ncyc;        // shadow
  int en_hist[$];                         // en of the last LAT cycles
  int chg_hist[$];                        // waveform switched at last LAT edges

  task automatic model_reset();
    m_busy = 0; m_phase = 0; m_per = 0; m_sreq = 0; m_pend = 0; m_done = 0;
    m_ftw = 0; m_pow = 0; m_wav = 0; m_ncyc = 0;
    s_ftw = 0; s_pow = 0; s_wav = 0; s_ncyc = 0;
    en_hist = {}; chg_hist = {};
    for (int i = 0; i < LAT; i++) begin
      en_hist.push_back(0);
      chg_hist.push_back(0);
    end
  endtask

  task automatic promote();
    m_ftw = s_ftw; m_pow = s_pow; m_wav = s_wav; m_ncyc = s_ncyc; m_pend = 0;
  endtask

  task automatic model_edge(input stim_t s);
    int accept, wrapped, fin, nxt, en_now, wav_now;
    if (s.rst) begin
      model_reset();
      return;
    end
    en_now  = m_busy;
    wav_now = m_wav;
    accept  = s.cv && !m_pend;
    nxt     = m_phase + m_ftw;
    wrapped = m_busy && (nxt >= MOD);
    nxt     = nxt % MOD;
    m_done  = 0;
    if (!m_busy) begin
      if (m_pend) promote();
      else if (accept) begin
        m_ftw = s.ftw; m_pow = s.pow; m_wav = s.wav; m_ncyc = s.ncyc;
      end
      m_busy = (s.start && !s.stop);
    end else begin
      fin = 0;
      if (m_ftw == 0 && (m_sreq || s.stop)) fin = 1;
      else if (wrapped) begin
        m_per++;
        if (m_sreq || (m_ncyc != 0 && m_per == m_ncyc)) fin = 1;
        else if (m_pend) begin
          promote();
          m_per = 0;
        end
      end
      if (accept) begin
        s_ftw = s.ftw; s_pow = s.pow; s_wav = s.wav; s_ncyc = s.ncyc;
        m_pend = 1;
      end
      if (s.stop) m_sreq = 1;
      m_phase = nxt;
      if (fin) begin
        m_busy = 0; m_done = 1; m_sreq = 0; m_per = 0; m_phase = 0;
      end
    end
    en_hist.push_front(en_now);
    chg_hist.push_front(m_wav != wav_now);
    void'(en_hist.pop_back());
    void'(chg_hist.pop_back());
  endtask

  function automatic int m_dv();
    int v = en_hist[LAT-1];
    foreach (chg_hist[i]) if (chg_hist[i] != 0) v = 0;
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("m_addr", 32'(addr), 32'(((m_phase >> (ACC - AD)) + m_pow) % (1 << AD)));
    chk("m_en", 32'(en), 32'(m_busy));
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_wav", 32'(wav_select), 32'(m_wav));
    chk("m_wrap", 32'(wrap), 32'(m_busy && (m_phase + m_ftw >= MOD)));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_ready", 32'(cfg_ready), 32'(!m_pend));
    chk("m_dv", 32'(data_valid), 32'(m_dv()));
  endtask

  // Drive one cycle of inputs, advance model and DUT by one edge, compare.
  task automatic cyc(input stim_t s);
    rst = s.rst; start = s.start; stop = s.stop; cfg_valid = s.cv;
    cfg_ftw = s.ftw; cfg_pow = s.pow; cfg_wav = s.wav; cfg_ncyc = s.ncyc;
    model_edge(s);
    @(posedge sclk);
    #1;
    model_check();
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, start: 1'b0, stop: 1'b0, cv: 1'b0,
          ftw: '0, pow: '0, wav: '0, ncyc: '0};
    return s;
  endfunction

  function automatic stim_t mkcfg(input logic [ACC-1:0] f, input logic [AD-1:0] p,
                                  input logic [1:0] w, input logic [CNT-1:0] n);
    stim_t s = idle();
    s.cv = 1'b1; s.ftw = f; s.pow = p; s.wav = w; s.ncyc = n;
    return s;
  endfunction

  function automatic stim_t mk(input logic r, input logic st, input logic sp);
    stim_t s = idle();
    s.rst = r; s.start = st; s.stop = sp;
    return s;
  endfunction

  task automatic wait_wrap(input string nm);
    int n = 0;
    while (wrap !== 1'b1 && n < 64) begin
      cyc(idle());
      n++;
    end
    if (n >= 64) chk({nm, "_wrap_timeout"}, 32'(n), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[13];
  stim_t s;

  initial begin
    int nw, nd, n, en_drop;
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cfg_ftw = '0; cfg_pow = '0; cfg_wav = '0; cfg_ncyc = '0;
    model_reset();

    // ftw=0x4000 gives a 4-cycle period with address step 0x400.
    tbl[0]  = '{mk(1,0,0),                          12'h000, 0, 0, 0, 0, 1};
    tbl[1]  = '{mkcfg(16'h4000, 12'h010, 2'd1, 16'd2), 12'h010, 0, 0, 0, 0, 1};
    tbl[2]  = '{mk(0,1,1),                          12'h010, 0, 0, 0, 0, 1};
    tbl[3]  = '{mk(0,1,0),                          12'h010, 1, 0, 0, 0, 1};
    tbl[4]  = '{idle(),                             12'h410, 1, 0, 0, 1, 1};
    tbl[5]  = '{idle(),                             12'h810, 1, 0, 0, 1, 1};
    tbl[6]  = '{idle(),                             12'hC10, 1, 1, 0, 1, 1};
    tbl[7]  = '{idle(),                             12'h010, 1, 0, 0, 1, 1};
    tbl[8]  = '{idle(),                             12'h410, 1, 0, 0, 1, 1};
    tbl[9]  = '{idle(),                             12'h810, 1, 0, 0, 1, 1};
    tbl[10] = '{idle(),                             12'hC10, 1, 1, 0, 1, 1};
    tbl[11] = '{idle(),                             12'h010, 0, 0, 1, 1, 1};
    tbl[12] = '{idle(),                             12'h010, 0, 0, 0, 0, 1};

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].s);
      chk("t_addr", 32'(addr), 32'(tbl[i].addr));
      chk("t_en", 32'(en), 32'(tbl[i].en));
      chk("t_wrap", 32'(wrap), 32'(tbl[i].wrap));
      chk("t_done", 32'(done), 32'(tbl[i].done));
      chk("t_dv", 32'(data_valid), 32'(tbl[i].dv));
      chk("t_rdy", 32'(cfg_ready), 32'(tbl[i].rdy));
    end

    // Burst of 2 periods at ftw=0x1000.
    cyc(mk(1,0,0));
    cyc(mkcfg(16'h1000, 12'h000, 2'd0, 16'd2));
    cyc(mk(0,1,0));
    nw = 0; nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (k < 32) chk("s1_addr", 32'(addr), 32'((k % 16) * 256));
      if (k == 31) chk("s1_en_last", 32'(en), 32'd1);
      if (k == 32) chk("s1_en_off", 32'(en), 32'd0);
      nw += int'(wrap);
      nd += int'(done);
      cyc(idle());
    end
    chk("s1_wraps", 32'(nw), 32'd2);
    chk("s1_dones", 32'(nd), 32'd1);

    // Reconfigure mid-period while running continuously.
    cyc(mk(1,0,0));
    cyc(mkcfg(16'h1000, 12'h000, 2'd0, 16'd0));
    cyc(mk(0,1,0));
    for (int k = 0; k < 4; k++) cyc(idle());
    cyc(mkcfg(16'h1000, 12'h800, 2'd2, 16'd0));
    chk("s2_ready_low", 32'(cfg_ready), 32'd0);
    wait_wrap("s2");
    cyc(idle());
    chk("s2_wav", 32'(wav_select), 32'd2);
    chk("s2_addr", 32'(addr), 32'h800);
    chk("s2_dv_blank", 32'(data_valid), 32'd0);
    cyc(idle());
    chk("s2_dv_back", 32'(data_valid), 32'd1);
    chk("s2_ready_back", 32'(cfg_ready), 32'd1);

    // Config accepted in the wrap cycle takes effect one period later.
    cyc(mk(1,0,0));
    cyc(mkcfg(16'h1000, 12'h000, 2'd1, 16'd0));
    cyc(mk(0,1,0));
    wait_wrap("s3a");
    cyc(mkcfg(16'h1000, 12'h100, 2'd3, 16'd0));
    chk("s3_wav_held", 32'(wav_select), 32'd1);
    chk("s3_pending", 32'(cfg_ready), 32'd0);
    wait_wrap("s3b");
    cyc(idle());
    chk("s3_wav_new", 32'(wav_select), 32'd3);
    chk("s3_addr_new", 32'(addr), 32'h100);

    // Graceful stop mid-period.
    cyc(mk(1,0,0));
    cyc(mkcfg(16'h1000, 12'h000, 2'd0, 16'd0));
    cyc(mk(0,1,0));
    for (int k = 0; k < 3; k++) cyc(idle());
    cyc(mk(0,0,1));
    n = 0; en_drop = 0;
    while (done !== 1'b1 && n < 40) begin
      if (en !== 1'b1) en_drop = 1;
      cyc(idle());
      n++;
    end
    chk("s4_cycles_to_done", 32'(n), 32'd12);
    chk("s4_en_held", 32'(en_drop), 32'd0);
    chk("s4_en_off", 32'(en), 32'd0);

    // Stop with a zero tuning word.
    cyc(mk(1,0,0));
    cyc(mkcfg(16'h0000, 12'h000, 2'd0, 16'd0));
    cyc(mk(0,1,0));
    cyc(idle());
    chk("s4z_busy", 32'(busy), 32'd1);
    cyc(mk(0,0,1));
    chk("s4z_idle", 32'(busy), 32'd0);
    chk("s4z_done", 32'(done), 32'd1);
    cyc(idle());
    chk("s4z_done_pulse", 32'(done), 32'd0);

    // start and stop together in IDLE.
    cyc(mk(0,1,1));
    chk("s5_busy", 32'(busy), 32'd0);

    // Reset mid-burst with a pending config.
    cyc(mk(1,0,0));
    cyc(mkcfg(16'h1000, 12'h040, 2'd1, 16'd0));
    cyc(mk(0,1,0));
    for (int k = 0; k < 3; k++) cyc(idle());
    cyc(mkcfg(16'h2000, 12'h123, 2'd2, 16'd5));
    chk("s6_pending", 32'(cfg_ready), 32'd0);
    cyc(mk(1,0,0));
    chk("s6_addr", 32'(addr), 32'd0);
    chk("s6_en", 32'(en), 32'd0);
    chk("s6_wav", 32'(wav_select), 32'd0);
    chk("s6_dv", 32'(data_valid), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_wrap", 32'(wrap), 32'd0);
    chk("s6_done", 32'(done), 32'd0);
    chk("s6_ready", 32'(cfg_ready), 32'd1);
    cyc(idle());
    chk("s6_no_done", 32'(done), 32'd0);

    // Random traffic against the model.
    cyc(mk(1,0,0));
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 499) == 0);
      s.start = ($urandom_range(0, 7) == 0);
      s.stop  = ($urandom_range(0, 39) == 0);
      s.cv    = ($urandom_range(0, 5) == 0);
      s.ftw   = ($urandom_range(0, 15) == 0) ? 16'h0000
                                              : 16'($urandom_range(16'h0800, 16'h6000));
      s.pow   = 12'($urandom);
      s.wav   = 2'($urandom);
      s.ncyc  = 16'($urandom_range(0, 3));
      cyc(s);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_ctrl.md
# dds_ctrl

Sequencer for the DDS waveform path: it owns the phase accumulator and produces the `addr`, `en` and `wav_select` that drive the four-ROM waveform selector, plus a `data_valid` strobe aligned to ROM output. Frequency, phase offset, waveform and burst length arrive through a valid/ready config port. They are applied only at a phase wrap, so every output period is glitch-free. The block sits between the register/host interface and the waveform ROM selector.

## Interface
- `ACC_BIT`, 32, phase accumulator width.
- `ADDR_BIT`, 12, ROM address width; the top `ADDR_BIT` bits of the accumulator form the address (`ADDR_BIT <= ACC_BIT`).
- `CNT_BIT`, 16, burst period counter width.
- `ROM_LAT`, 1, ROM read latency in cycles (≥1).

Ports:
- `sclk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin output, level-sampled, honoured in IDLE only.
- `stop` in 1: request graceful stop at next wrap.
- `cfg_valid` in 1 / `cfg_ready` out 1: config handshake; a transfer occurs when both are high.
- `cfg_ftw` in `ACC_BIT`: frequency tuning word.
- `cfg_pow` in `ADDR_BIT`: phase offset in address units.
- `cfg_wav` in 2: waveform code.
- `cfg_ncyc` in `CNT_BIT`: periods per burst; 0 = continuous.
- `wav_select` out 2, `addr` out `ADDR_BIT`, `en` out 1: drive the ROM selector.
- `data_valid` out 1: ROM data for current waveform is valid this cycle.
- `busy` out 1: state ≠ IDLE.
- `wrap` out 1: 1-cycle pulse on accumulator carry.
- `done` out 1: 1-cycle pulse when a burst or stop completes.

## Operation
- Registers:
  - Shadow config: ftw, pow, wav, ncyc, plus a `pending` flag.
  - Active config: ftw_a, pow_a, wav_a, ncyc_a.
  - `acc`, `pcnt` (completed periods), `stop_req`, state.
- Config port:
  - `cfg_ready = ~pending`.
  - In IDLE, an accepted config writes the active registers directly; `pending` stays 0.
  - In RUN, an accepted config writes the shadow and sets `pending`.
- States:
  - IDLE: `acc`=0, `pcnt`=0, `en`=0.
  - IDLE→RUN on `start & ~stop`. If `start` and `stop` are both high in IDLE, stop wins and the block stays in IDLE.
  - RUN: each cycle `acc <= acc + ftw_a` mod 2^ACC_BIT; `wrap` = carry out of that add.
- On a wrap in RUN, in priority order:
  1. `pcnt++`.
  2. If `stop_req`, or `ncyc_a≠0` and `pcnt+1 == ncyc_a`: go to IDLE, pulse `done`, clear `stop_req`.
  3. Else, if `pending`: copy shadow→active, clear `pending`, clear `pcnt` to 0.
- `stop` in RUN sets `stop_req`.
  - If `ftw_a == 0`, no wrap can ever occur, so RUN→IDLE happens on the next edge with a `done` pulse.
- Same-cycle config accept and wrap: the new config is not applied at this wrap; it is applied at the next one.
- Outputs:
  - `addr = acc[ACC_BIT-1 -: ADDR_BIT] + pow_a`, mod 2^ADDR_BIT.
  - `wav_select = wav_a`.
  - `en = (state == RUN)`.
  - All of these derive from registers only; there is no combinational path from inputs.
- `data_valid` is `en` delayed `ROM_LAT` cycles, forced low for the `ROM_LAT` cycles following any `wav_select` change (blanking the stale output of the newly selected ROM).
- Reset values: `acc`=0, active and shadow config 0 (SIN, ftw=0), `pending`=0, state IDLE. Resulting outputs: `addr`=0, `en`=0, `wav_select`=0, `data_valid`=0, `busy`=0, `wrap`=0, `done`=0, `cfg_ready`=1.
- Reset asserted mid-burst returns the block to its reset state at the next edge. There is no `done` pulse and any pending config is discarded.

## Timing
- `start` sampled at edge T:
  - `en`=1 and `addr`=pow_a from T+1.
  - `addr` advances every cycle after that.
  - `data_valid` is high from T+1+ROM_LAT.
- A wrap on the edge at T (the carry computed in cycle T−1) updates the active config, `addr` and `wav_select` together at T. `wrap` is high during cycle T−1.
- Burst end: `done` is high in the cycle after the final wrap; `en`=0 in the same cycle. `data_valid` falls ROM_LAT cycles later.
- Config throughput: one accepted transfer per period while in RUN; unlimited in IDLE.

## Structure
- Shared package `dds_pkg` holds:
  - Waveform codes SIN=2'b00, TIR=2'b01, SAW=2'b10, SQU=2'b11.
  - The state encoding (IDLE, RUN).
- One sub-module, `dds_phase_acc`: accumulator register, carry/wrap generation and address offset add.
- The FSM, config shadowing, period counter and `data_valid` delay line stay in `dds_ctrl`.

## Test plan
Common settings: `ACC_BIT`=16, `ADDR_BIT`=12, `ROM_LAT`=1.
- Load ftw=0x1000, pow=0, ncyc=2 in IDLE, then `start` → `addr` = 0, 256, …, 3840, then repeats. Exactly 2 `wrap` pulses; `done` pulses once; `en` is low 32 cycles after `start`.
- RUN continuous with ftw=0x1000, then config wav=SAW, pow=0x800 mid-period → `cfg_ready` falls. At the next wrap, `wav_select`=2 and `addr`=0x800, and `data_valid` is low for exactly 1 cycle.
- Accept a config in the same cycle as a wrap → it is applied one period later, not at this wrap.
- `stop` mid-period with ftw=0x1000 → `en` stays high until the period completes, then `done`. With ftw=0, `stop` → IDLE on the next edge.
- `start` and `stop` together in IDLE → stays in IDLE, `busy`=0.
- Assert `rst` mid-burst with `pending`=1 → next cycle all outputs at reset values, `cfg_ready`=1, no `done` pulse.
